// File: rtl/shift_unit.sv
// Multi-cycle shifter: one variable stage reused for L cycles, stage k shifting
// by 2^k when shamt[k] is set. Valid/ready handshake on both sides.
module shift_unit #(
   parameter  int N = 32,
   localparam int L = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [L-1:0] in_shamt,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;
   localparam logic [L:0] C_N    = (L+1)'(N);

   state_t       r_state;
   logic [N-1:0] r_work;
   logic [L-1:0] r_shamt;
   logic [1:0]   r_op;
   logic [L-1:0] r_k;
   logic         r_in_ready;
   logic         r_out_valid;
   logic [N-1:0] r_out_data;

   logic [L-1:0] w_dist;
   logic [L:0]   w_rdist;
   logic [N-1:0] w_srl;
   logic [N-1:0] w_shifted;
   logic [N-1:0] w_step;
   logic         w_last;

   // Single shared stage; distance is 2^k, never zero, so N-dist stays < N.
   always_comb begin
      w_dist    = L'(1) << r_k;
      w_rdist   = C_N - (L+1)'(w_dist);
      w_srl     = r_work >> w_dist;
      w_shifted = w_srl;
      case (r_op)
         OP_SLL:  w_shifted = r_work << w_dist;
         OP_SRL:  w_shifted = w_srl;
         OP_SRA:  w_shifted = $unsigned($signed(r_work) >>> w_dist);
         OP_ROR:  w_shifted = w_srl | (r_work << w_rdist);
         default: w_shifted = w_srl;
      endcase
      w_step = r_shamt[r_k] ? w_shifted : r_work;
      w_last = (r_k == L'(L-1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_work      <= '0;
         r_shamt     <= '0;
         r_op        <= '0;
         r_k         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_work     <= in_data;
                  r_shamt    <= in_shamt;
                  r_op       <= in_op;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_work <= w_step;
               r_k    <= r_k + L'(1);
               if (w_last) begin
                  r_k         <= '0;
                  r_out_data  <= w_step;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               // Leaving DONE lands in IDLE; acceptance waits a full cycle.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_shift_unit.sv
// Directed N=32 checks plus randomized scoreboard runs at N=8/16/32.
module tb_shift_unit;

   localparam int REQS = 3400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference built straight from the operator definitions.
   function automatic logic [63:0] ref_model(input int n, input logic [63:0] d,
                                             input int s, input int op);
      logic [63:0] mask, r;
      mask = (64'd1 << n) - 64'd1;
      d    = d & mask;
      case (op)
         0: r = (d << s) & mask;
         1: r = d >> s;
         2: r = (d >> s) | (d[n-1] ? (mask & ~(mask >> s)) : 64'd0);
         default: r = (s == 0) ? d : (((d >> s) | (d << (n - s))) & mask);
      endcase
      return r;
   endfunction

   // ---------------- directed instance ----------------
   logic        d_rst, d_iv, d_ir, d_ov, d_ordy;
   logic [31:0] d_id, d_od;
   logic [4:0]  d_sh;
   logic [1:0]  d_op;

   shift_unit #(.N(32)) u_dir (
      .clk(clk), .rst(d_rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
      .in_shamt(d_sh), .in_op(d_op), .out_valid(d_ov), .out_ready(d_ordy), .out_data(d_od)
   );

   task automatic do_req(input string nm, input logic [31:0] data, input logic [4:0] sh,
                         input logic [1:0] op, input logic [31:0] exp);
      int lat;
      @(negedge clk);
      d_iv = 1'b1; d_id = data; d_sh = sh; d_op = op; d_ordy = 1'b0;
      chk({nm, "_in_ready"}, 64'(d_ir), 64'd1);
      @(posedge clk); #1;
      d_iv = 1'b0; d_id = ~data; d_sh = ~sh; d_op = ~op;
      lat = 0;
      while (!d_ov && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'd5);
      chk({nm, "_data"}, 64'(d_od), 64'(exp));
      d_ordy = 1'b1;
      @(posedge clk); #1;
      d_ordy = 1'b0;
      chk({nm, "_idle_ready"}, 64'(d_ir), 64'd1);
      chk({nm, "_idle_valid"}, 64'(d_ov), 64'd0);
   endtask

   // ---------------- random instances ----------------
   logic rrst;

   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int NW = 8 << g;
      localparam int LW = $clog2(NW);
      logic          iv, ir, ov, ordy;
      logic [NW-1:0] id, od;
      logic [LW-1:0] sh;
      logic [1:0]    op;
      logic [NW-1:0] q[$];
      int            pushed;
      bit            done;

      shift_unit #(.N(NW)) u_rnd (
         .clk(clk), .rst(rrst), .in_valid(iv), .in_ready(ir), .in_data(id),
         .in_shamt(sh), .in_op(op), .out_valid(ov), .out_ready(ordy), .out_data(od)
      );

      initial begin
         iv = 1'b0; id = '0; sh = '0; op = '0; pushed = 0; done = 1'b0;
         wait (!rrst);
         while (pushed < REQS) begin
            @(negedge clk);
            iv = ($urandom_range(3) != 0);
            id = NW'($urandom);
            sh = LW'($urandom);
            op = 2'($urandom);
            if (iv && ir) begin
               q.push_back(NW'(ref_model(NW, 64'(id), int'(sh), int'(op))));
               pushed++;
            end
         end
         @(negedge clk);
         iv = 1'b0;
         for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
         chk($sformatf("rnd%0d_drain", NW), 64'(q.size()), 64'd0);
         done = 1'b1;
      end

      initial begin
         ordy = 1'b0;
         forever begin
            @(negedge clk);
            ordy = ($urandom_range(3) != 0);
            if (ov && ordy) begin
               if (q.size() == 0) begin
                  chk($sformatf("rnd%0d_spurious", NW), 64'd1, 64'd0);
               end else begin
                  logic [NW-1:0] e;
                  e = q.pop_front();
                  chk($sformatf("rnd%0d_result", NW), 64'(od), 64'(e));
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int t;
      rrst = 1'b1;
      d_rst = 1'b1; d_iv = 1'b0; d_id = '0; d_sh = '0; d_op = '0; d_ordy = 1'b0;
      #3;
      chk("rst_in_ready", 64'(d_ir), 64'd1);
      chk("rst_out_valid", 64'(d_ov), 64'd0);
      chk("rst_out_data", 64'(d_od), 64'd0);
      #12;
      d_rst = 1'b0; rrst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(d_ir), 64'd1);

      do_req("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
      do_req("sra4",  32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
      do_req("srl4",  32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
      do_req("ror4",  32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F);
      do_req("sll0",  32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
      do_req("ror0",  32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678);
      do_req("sra31", 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000);

      // Backpressure with a persistent, changing request at the input.
      @(negedge clk);
      d_iv = 1'b1; d_id = 32'h1234_5678; d_sh = 5'd8; d_op = 2'b00; d_ordy = 1'b0;
      @(posedge clk); #1;
      t = 0;
      while (!d_ov && t < 20) begin
         d_id = ~d_id; d_sh = d_sh + 5'd3; d_op = d_op + 2'd1;
         @(posedge clk); #1;
         t++;
      end
      chk("bp_latency", 64'(t), 64'd5);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 64'(d_ov), 64'd1);
         chk("bp_in_ready", 64'(d_ir), 64'd0);
         chk("bp_data", 64'(d_od), 64'h3456_7800);
         d_id = ~d_id;
         @(posedge clk); #1;
      end
      d_ordy = 1'b1; d_iv = 1'b0;
      @(posedge clk); #1;
      d_ordy = 1'b0;
      chk("bp_release_valid", 64'(d_ov), 64'd0);
      chk("bp_release_ready", 64'(d_ir), 64'd1);
      chk("bp_release_data", 64'(d_od), 64'h3456_7800);
      @(posedge clk); #1;
      chk("bp_idle_hold", 64'(d_ir), 64'd1);

      // Asynchronous reset in BUSY at k=2.
      @(negedge clk);
      d_iv = 1'b1; d_id = 32'h0000_00FF; d_sh = 5'd1; d_op = 2'b00;
      @(posedge clk); #1;
      d_iv = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      d_rst = 1'b1;
      #1;
      chk("abort_in_ready", 64'(d_ir), 64'd1);
      chk("abort_out_valid", 64'(d_ov), 64'd0);
      chk("abort_out_data", 64'(d_od), 64'd0);
      #1;
      d_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("abort_no_result", 64'(d_ov), 64'd0);
      end
      do_req("sra8_after_rst", 32'hFFFF_FF00, 5'd8, 2'b10, 32'hFFFF_FFFF);

      t = 0;
      while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && t < 60000) begin
         @(negedge clk);
         t++;
      end
      if (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done))
         chk("rnd_timeout", 64'd1, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter N, default 32, datapath width in bits; SHALL be a power of two, >= 2.
REQ-002 Derived constant L = $clog2(N); this is the shift-amount width and the number of shift stages.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 in_data  input  N  operand.
REQ-008 in_shamt  input  L  shift amount, unsigned, 0..N-1.
REQ-009 in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  N  result.

Function
REQ-013 The unit SHALL be a three-state FSM: IDLE, BUSY, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1: the unit SHALL latch in_data into the working register, latch in_shamt and in_op, clear the stage counter k to 0, and go to BUSY.
REQ-016 IDLE with in_valid=0: the unit SHALL stay in IDLE and hold all registers.
REQ-017 BUSY, each edge, stage k: if shamt[k]=1, the working register SHALL be shifted by 2^k per op; otherwise it SHALL be held.
REQ-018 BUSY stage op rules:
- SLL: zero-fill from the LSB side.
- SRL: zero-fill from the MSB side.
- SRA: fill from the MSB side with working-register bit N-1.
- ROR: bits shifted out of the LSB side re-enter at the MSB side.
REQ-019 BUSY: k SHALL increment each edge; the edge processing stage k=L-1 SHALL transition to DONE.
REQ-020 Latency SHALL be fixed at L edges from the accepting edge to out_valid=1, for every shamt including 0; there is no early exit.
REQ-021 DONE: out_data SHALL equal the working register and SHALL be stable while out_ready=0.
REQ-022 DONE with out_ready=1: the unit SHALL return to IDLE on that edge; out_data keeps its last value.
REQ-023 A new request SHALL NOT be accepted on the edge that leaves DONE (in_ready=0 in DONE); throughput is at most one result per L+2 cycles.
REQ-024 in_data, in_shamt and in_op SHALL be ignored outside IDLE; mid-operation input changes SHALL NOT affect the result.
REQ-025 The result SHALL equal the RV32I-compatible single-step result for N=32: in<<s, in>>s, $signed(in)>>>s, and (in>>s)|(in<<(N-s)) for s!=0 (ROR, s=0 gives in).
REQ-026 All arithmetic on k and shamt SHALL be unsigned, L bits wide.
REQ-027 The datapath SHALL implement exactly one per-stage shifter, time-multiplexed across the L stages; it SHALL NOT unroll L stages.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force: state IDLE, k=0, working register 0, latched shamt and op 0.
REQ-029 Outputs while rst=1 and after release: in_ready=1, out_valid=0, out_data=0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation; the result SHALL NOT be delivered.
REQ-031 First request after reset release SHALL complete normally with the full L-cycle latency.

Verification
REQ-032 SLL, N=32, in_data=0x00000001, shamt=31 -> out_valid rises 5 edges after accept, out_data=0x80000000.
REQ-033 in_data=0x80000000, shamt=4:
- SRA -> 0xF8000000.
- SRL -> 0x08000000.
REQ-034 ROR, in_data=0x000000F1, shamt=4 -> 0x1000000F; SLL, 0xDEADBEEF, shamt=0 -> 0xDEADBEEF, still 5-edge latency.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE, with in_valid=1 and new in_data toggling -> out_data and out_valid held, in_ready=0, no new request accepted. out_ready=1 -> IDLE on the next edge; in_ready=1 the following cycle.
REQ-036 rst pulsed asynchronously between edges while in BUSY at k=2 -> in_ready=1, out_valid=0 and out_data=0 immediately. A following SRA of 0xFFFFFF00 by 8 -> 0xFFFFFFFF.
REQ-037 Randomised self-check at N=8, 16 and 32 against the REQ-025 expressions: 10k requests, all ops, random out_ready stalls, zero mismatches.
